assembler: RTL and testbench

ASSEMBLER -- requirements
Module: assembler

---
 rtl/assembler_pkg.sv | 51 +++++
 rtl/packet_fifo.sv | 49 ++++
 rtl/assembler.sv | 167 ++++++++++++++++
 tb/tb_assembler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assembler_pkg.sv
// Shared flit layout and packet slicing for the packet splitter and the assembler.
// Flit, MSB first: {vld, dest[NW], payload[17], pid[PW], src[NW], idx[2]}.
package assembler_pkg;

   localparam int PAYLOAD_W        = 17;
   localparam int IDX_W            = 2;
   localparam int FLITS_PER_PACKET = 4;
   localparam int PACKET_W         = PAYLOAD_W * FLITS_PER_PACKET;

   // LSB of each payload slice inside the 68-bit packet; idx0 lands at the top.
   localparam int SLICE0_LSB = 3 * PAYLOAD_W;
   localparam int SLICE1_LSB = 2 * PAYLOAD_W;
   localparam int SLICE2_LSB = 1 * PAYLOAD_W;
   localparam int SLICE3_LSB = 0;

   typedef enum logic [1:0] {
      SLOT_IDLE = 2'd0,
      SLOT_ACC1 = 2'd1,
      SLOT_ACC2 = 2'd2,
      SLOT_ACC3 = 2'd3
   } slot_state_t;

   function automatic int node_w(input int node_count);
      return (node_count > 1) ? $clog2(node_count) : 1;
   endfunction

   function automatic int flit_w(input int node_count, input int pid_w);
      return 1 + 2 * node_w(node_count) + PAYLOAD_W + pid_w + IDX_W;
   endfunction

   function automatic int src_lsb();
      return IDX_W;
   endfunction

   function automatic int pid_lsb(input int nw);
      return IDX_W + nw;
   endfunction

   function automatic int payload_lsb(input int nw, input int pid_w);
      return IDX_W + nw + pid_w;
   endfunction

   function automatic int dest_lsb(input int nw, input int pid_w);
      return IDX_W + nw + pid_w + PAYLOAD_W;
   endfunction

   function automatic int slice_lsb(input logic [IDX_W-1:0] idx);
      return (FLITS_PER_PACKET - 1 - int'(idx)) * PAYLOAD_W;
   endfunction

endpackage

// File: rtl/packet_fifo.sv
// First-word-fall-through FIFO for completed packets; head is visible combinationally.
module packet_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head_reg, tail_reg;
   logic [CW-1:0]    count_reg;
   logic             push_ok, pop_ok;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
   endfunction

   assign push_ok = push & (count_reg != CW'(DEPTH));
   assign pop_ok  = pop & (count_reg != '0);

   always_ff @(posedge clk) begin
      if (push_ok) mem[tail_reg] <= push_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         if (push_ok) tail_reg <= next_ptr(tail_reg);
         if (pop_ok)  head_reg <= next_ptr(head_reg);
         if (push_ok && !pop_ok)      count_reg <= count_reg + CW'(1);
         else if (pop_ok && !push_ok) count_reg <= count_reg - CW'(1);
      end
   end

   assign head_data = mem[head_reg];
   assign count     = count_reg;

endmodule

// File: rtl/assembler.sv
// Reassembles 4-flit packets per source node and queues completed packets
// for the consumer; protocol violations drop the partial packet and pulse error_out.
import assembler_pkg::*;

module assembler #(
   parameter int NODE_ID         = 0,
   parameter int NODE_COUNT      = 8,
   parameter int QUEUE_DEPTH     = 8,
   parameter int PACKET_ID_WIDTH = 5,
   localparam int NW = node_w(NODE_COUNT),
   localparam int FW = flit_w(NODE_COUNT, PACKET_ID_WIDTH)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ce,
   input  logic [FW-1:0]              input_data,
   input  logic                       valid_in,
   output logic                       assembler_ready,
   output logic [PACKET_W-1:0]        packet_out,
   output logic [NW-1:0]              node_src,
   output logic [PACKET_ID_WIDTH-1:0] packet_id,
   output logic                       valid_out,
   input  logic                       consumer_ready,
   output logic                       error_out
);

   localparam int PW      = PACKET_ID_WIDTH;
   localparam int ENTRY_W = PACKET_W + NW + PW;
   localparam int CW      = $clog2(QUEUE_DEPTH + 1);

   logic                 f_vld;
   logic [NW-1:0]        f_src, src_sel;
   logic [PW-1:0]        f_pid;
   logic [PAYLOAD_W-1:0] f_payload;
   logic [IDX_W-1:0]     f_idx;
   logic                 unused_dest;
   logic                 src_bad, accept;

   assign f_vld       = input_data[FW-1];
   assign f_src       = input_data[src_lsb() +: NW];
   assign f_pid       = input_data[pid_lsb(NW) +: PW];
   assign f_payload   = input_data[payload_lsb(NW, PW) +: PAYLOAD_W];
   assign f_idx       = input_data[IDX_W-1:0];
   assign unused_dest = ^input_data[dest_lsb(NW, PW) +: NW];

   // With a power-of-two node count every encodable src names a real node.
   generate
      if ((1 << NW) == NODE_COUNT) begin : g_src_full
         assign src_bad = 1'b0;
      end else begin : g_src_part
         assign src_bad = (f_src >= NW'(NODE_COUNT));
      end
   endgenerate

   assign src_sel = src_bad ? '0 : f_src;
   assign accept  = ce & valid_in & assembler_ready & f_vld;

   slot_state_t         state_reg [NODE_COUNT];
   slot_state_t         state_next[NODE_COUNT];
   logic [PACKET_W-1:0] buf_reg   [NODE_COUNT];
   logic [PACKET_W-1:0] buf_next  [NODE_COUNT];
   logic [PW-1:0]       pid_reg   [NODE_COUNT];
   logic [PW-1:0]       pid_next  [NODE_COUNT];

   slot_state_t         cur_state, upd_state;
   logic [PACKET_W-1:0] placed_buf, fresh_buf, upd_buf;
   logic [PW-1:0]       upd_pid;
   logic                flit_err, flit_done;

   // Evaluate the flit against the slot of its source.
   always_comb begin
      cur_state  = state_reg[src_sel];
      placed_buf = (f_idx == '0) ? '0 : buf_reg[src_sel];
      placed_buf[slice_lsb(f_idx) +: PAYLOAD_W] = f_payload;
      fresh_buf  = '0;
      fresh_buf[SLICE0_LSB +: PAYLOAD_W] = f_payload;
      flit_err   = src_bad | (f_idx != IDX_W'(cur_state)) |
                   ((cur_state != SLOT_IDLE) & (f_pid != pid_reg[src_sel]));
      upd_state  = cur_state;
      upd_buf    = placed_buf;
      upd_pid    = pid_reg[src_sel];
      flit_done  = 1'b0;
      if (flit_err) begin
         if (f_idx == '0) begin
            upd_state = SLOT_ACC1;
            upd_buf   = fresh_buf;
            upd_pid   = f_pid;
         end else begin
            upd_state = SLOT_IDLE;
            upd_buf   = '0;
         end
      end else begin
         if (f_idx == '0) upd_pid = f_pid;
         if (f_idx == IDX_W'(FLITS_PER_PACKET - 1)) begin
            upd_state = SLOT_IDLE;
            flit_done = 1'b1;
         end else begin
            upd_state = slot_state_t'(cur_state + 2'd1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NODE_COUNT; i++) begin
         state_next[i] = state_reg[i];
         buf_next[i]   = buf_reg[i];
         pid_next[i]   = pid_reg[i];
         if (accept && !src_bad && (src_sel == NW'(i))) begin
            state_next[i] = upd_state;
            buf_next[i]   = upd_buf;
            pid_next[i]   = upd_pid;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NODE_COUNT; i++) begin
            state_reg[i] <= SLOT_IDLE;
            buf_reg[i]   <= '0;
            pid_reg[i]   <= '0;
         end
      end else if (ce) begin
         for (int i = 0; i < NODE_COUNT; i++) begin
            state_reg[i] <= state_next[i];
            buf_reg[i]   <= buf_next[i];
            pid_reg[i]   <= pid_next[i];
         end
      end
   end

   logic error_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  error_reg <= 1'b0;
      else if (ce) error_reg <= accept & flit_err;
   end

   assign error_out = error_reg;

   logic [ENTRY_W-1:0] head_data;
   logic [CW-1:0]      fifo_count;
   logic               fifo_push, fifo_pop;

   assign fifo_push = accept & flit_done;
   assign fifo_pop  = ce & valid_out & consumer_ready;

   packet_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({placed_buf, f_src, f_pid}),
      .pop       (fifo_pop),
      .head_data (head_data),
      .count     (fifo_count)
   );

   assign assembler_ready = ce & (fifo_count < CW'(QUEUE_DEPTH));
   assign valid_out       = (fifo_count != '0);
   assign packet_out      = valid_out ? head_data[ENTRY_W-1 -: PACKET_W] : '0;
   assign node_src        = valid_out ? head_data[PW +: NW] : '0;
   assign packet_id       = valid_out ? head_data[PW-1:0] : '0;

endmodule

// File: tb/tb_assembler.sv
// Directed bench for the assembler with a queue-based reference model and
// a per-cycle output compare.
module tb_assembler;

   localparam int NW = 3;
   localparam int PW = 5;
   localparam int FW = 31;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ce = 1'b0;
   logic [FW-1:0] input_data = '0;
   logic          valid_in = 1'b0;
   logic          consumer_ready = 1'b0;
   logic          assembler_ready;
   logic [67:0]   packet_out;
   logic [NW-1:0] node_src;
   logic [PW-1:0] packet_id;
   logic          valid_out;
   logic          error_out;

   always #5 clk = ~clk;

   assembler #(
      .NODE_ID         (0),
      .NODE_COUNT      (8),
      .QUEUE_DEPTH     (8),
      .PACKET_ID_WIDTH (5)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ce              (ce),
      .input_data      (input_data),
      .valid_in        (valid_in),
      .assembler_ready (assembler_ready),
      .packet_out      (packet_out),
      .node_src        (node_src),
      .packet_id       (packet_id),
      .valid_out       (valid_out),
      .consumer_ready  (consumer_ready),
      .error_out       (error_out)
   );

   int checks = 0;
   int errors = 0;
   int err_seen = 0;
   int pops_seen = 0;
   bit check_en = 1'b0;

   task automatic chk(input string name, input logic [67:0] act, input logic [67:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: per-source word collection plus a queue of finished packets.
   typedef struct {
      logic [67:0] data;
      logic [2:0]  src;
      logic [4:0]  pid;
   } pkt_t;

   pkt_t        exp_q[$];
   int          exp_idx[8];
   logic [4:0]  exp_pid[8];
   logic [16:0] words[8][4];
   bit          exp_err;

   task automatic model_reset();
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_idx[i] = 0;
      exp_err = 1'b0;
   endtask

   task automatic model_step();
      int          cnt;
      bit          acc, pop, err, done;
      int          s, idx;
      logic [4:0]  pid;
      logic [16:0] pl;
      pkt_t        p;
      cnt  = exp_q.size();
      acc  = ce && (cnt < 8) && valid_in && input_data[FW-1];
      pop  = ce && (cnt != 0) && consumer_ready;
      err  = 1'b0;
      done = 1'b0;
      if (acc) begin
         s   = int'(input_data[4:2]);
         idx = int'(input_data[1:0]);
         pid = input_data[9:5];
         pl  = input_data[26:10];
         if (idx != exp_idx[s] || (exp_idx[s] != 0 && pid != exp_pid[s])) begin
            err = 1'b1;
            if (idx == 0) begin
               words[s][0] = pl;
               exp_pid[s]  = pid;
               exp_idx[s]  = 1;
            end else begin
               exp_idx[s] = 0;
            end
         end else begin
            words[s][idx] = pl;
            if (idx == 0) exp_pid[s] = pid;
            if (idx == 3) begin
               done       = 1'b1;
               exp_idx[s] = 0;
               p.data = {words[s][0], words[s][1], words[s][2], words[s][3]};
               p.src  = 3'(s);
               p.pid  = exp_pid[s];
            end else begin
               exp_idx[s] = idx + 1;
            end
         end
      end
      if (pop) void'(exp_q.pop_front());
      if (done) exp_q.push_back(p);
      if (ce) exp_err = err;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         if (exp_q.size() != 0) begin
            chk("valid_out", valid_out, 1'b1);
            chk("packet_out", packet_out, exp_q[0].data);
            chk("node_src", node_src, exp_q[0].src);
            chk("packet_id", packet_id, exp_q[0].pid);
         end else begin
            chk("valid_out", valid_out, 1'b0);
            chk("packet_out idle", packet_out, 68'h0);
            chk("node_src idle", node_src, 3'h0);
            chk("packet_id idle", packet_id, 5'h0);
         end
         chk("error_out", error_out, exp_err);
         chk("assembler_ready", assembler_ready, ce && (exp_q.size() < 8));
         if (error_out === 1'b1) begin
            err_seen++;
            $display("error pulse at %0t", $time);
         end
         if (valid_out === 1'b1 && consumer_ready && ce) begin
            pops_seen++;
            $display("pkt src=%0d pid=%0d data=%h", node_src, packet_id, packet_out);
         end
      end
   end

   function automatic logic [FW-1:0] flit(input bit v, input logic [2:0] src, input logic [4:0] pid,
                                          input logic [1:0] idx, input logic [16:0] pl);
      logic [2:0] dest;
      dest = src ^ 3'd5;
      return {v, dest, pl, pid, src, idx};
   endfunction

   task automatic send(input bit v, input logic [2:0] src, input logic [4:0] pid,
                       input logic [1:0] idx, input logic [16:0] pl);
      valid_in   = 1'b1;
      input_data = flit(v, src, pid, idx, pl);
      tick();
      valid_in   = 1'b0;
   endtask

   task automatic idle(input int n);
      valid_in = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_pkt(input logic [2:0] src, input logic [4:0] pid, input logic [16:0] base);
      for (int i = 0; i < 4; i++) send(1'b1, src, pid, 2'(i), base + 17'(i));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int e0, p0;
      model_reset();
      ce = 1'b1;
      consumer_ready = 1'b1;
      check_en = 1'b1;
      idle(2);
      rst_n = 1'b1;
      chk("reset ready", assembler_ready, 1'b1);
      chk("reset valid", valid_out, 1'b0);
      idle(1);

      // Single packet, with an invalid-flit that must be ignored.
      send(1'b0, 3'd2, 5'd5, 2'd3, 17'h1FFFF);
      send(1'b1, 3'd2, 5'd5, 2'd0, 17'h1AAAA);
      send(1'b1, 3'd2, 5'd5, 2'd1, 17'h05555);
      send(1'b1, 3'd2, 5'd5, 2'd2, 17'h1F0F0);
      chk("single pre valid", valid_out, 1'b0);
      send(1'b1, 3'd2, 5'd5, 2'd3, 17'h00F0F);
      chk("single valid", valid_out, 1'b1);
      chk("single data", packet_out, 68'hD55515557E1E00F0F);
      chk("single src", node_src, 3'd2);
      chk("single pid", packet_id, 5'd5);
      idle(2);

      // Interleaved sources.
      e0 = err_seen;
      p0 = pops_seen;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 3'd1, 5'd3, 2'(i), 17'h10000 + 17'(i));
         send(1'b1, 3'd3, 5'd7, 2'(i), 17'h00100 + 17'(i));
      end
      idle(3);
      chk("interleave errors", 32'(err_seen - e0), 0);
      chk("interleave pkts", 32'(pops_seen - p0), 2);

      // Out-of-order index, then recovery.
      e0 = err_seen;
      send(1'b1, 3'd0, 5'd9, 2'd0, 17'h00001);
      send(1'b1, 3'd0, 5'd9, 2'd2, 17'h00002);
      chk("order error pulse", error_out, 1'b1);
      idle(2);
      chk("order errors", 32'(err_seen - e0), 1);
      chk("order no output", valid_out, 1'b0);
      p0 = pops_seen;
      send_pkt(3'd0, 5'd9, 17'h0A000);
      idle(2);
      chk("order recovery pkts", 32'(pops_seen - p0), 1);

      // Backpressure: fill the queue, try one more, then drain.
      consumer_ready = 1'b0;
      for (int s = 0; s < 8; s++) send_pkt(3'(s), 5'(s + 10), 17'(s * 16));
      chk("full ready", assembler_ready, 1'b0);
      send(1'b1, 3'd0, 5'd1, 2'd0, 17'h1234);
      idle(2);
      chk("full hold valid", valid_out, 1'b1);
      p0 = pops_seen;
      consumer_ready = 1'b1;
      idle(10);
      chk("drain pkts", 32'(pops_seen - p0), 8);
      chk("drain ready", assembler_ready, 1'b1);

      // Reset with a queued packet and a partial one in flight.
      consumer_ready = 1'b0;
      send_pkt(3'd6, 5'd2, 17'h0C000);
      send(1'b1, 3'd4, 5'd2, 2'd0, 17'h04000);
      send(1'b1, 3'd4, 5'd2, 2'd1, 17'h04001);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("reset mid valid", valid_out, 1'b0);
      chk("reset mid data", packet_out, 68'h0);
      chk("reset mid error", error_out, 1'b0);
      idle(1);
      rst_n = 1'b1;
      consumer_ready = 1'b1;
      e0 = err_seen;
      send(1'b1, 3'd4, 5'd2, 2'd2, 17'h04002);
      chk("reset stale error", error_out, 1'b1);
      idle(2);
      chk("reset errors", 32'(err_seen - e0), 1);

      // Clock enable low: nothing moves.
      consumer_ready = 1'b0;
      send_pkt(3'd5, 5'd4, 17'h05000);
      idle(1);
      ce = 1'b0;
      consumer_ready = 1'b1;
      send(1'b1, 3'd5, 5'd4, 2'd0, 17'h1EEEE);
      send(1'b1, 3'd6, 5'd1, 2'd0, 17'h1DDDD);
      idle(2);
      chk("ce low valid held", valid_out, 1'b1);
      chk("ce low src held", node_src, 3'd5);
      chk("ce low ready", assembler_ready, 1'b0);
      ce = 1'b1;
      e0 = err_seen;
      p0 = pops_seen;
      idle(2);
      send_pkt(3'd5, 5'd4, 17'h05100);
      idle(3);
      chk("ce resume errors", 32'(err_seen - e0), 0);
      chk("ce resume pkts", 32'(pops_seen - p0), 2);

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
